swd_bridge_top: RTL and testbench

Bit-level bridge between an SPI-style host port and a two-wire SWD target port. The host shifts bits in on `mosi` and out on `miso`. The block drives them onto, or samples them from, the bidirectional `swdio` line, and regenerates `swclk` from the host clock. It is the top level of the probe datapath and sits directly between the SPI host pins and the SWD connector. It adds no protocol framing: line reset, idle and packet sequences are produced bit-for-bit by the host.

---
 rtl/swd_bridge_top.sv | 128 ++++++++++++
 tb/tb_swd_bridge_top.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/swd_bridge_top.sv
// swd_bridge_top: bit-level bridge between an SPI-style host port and an SWD
// target port. The host supplies every SWD bit (line reset, idle, packets);
// this block only steers each bit onto or off the swdio wire and regenerates
// swclk. Every direction change passes through one RELEASE (turnaround) cycle,
// so the probe and the target never drive swdio at the same time.
//
// Note: despite its name, rst_n is an active-high synchronous reset
// (1 = reset), sampled on rising sck.

module swd_bridge_top (
   input  logic sck,
   input  logic rst_n,
   input  logic mosi,
   input  logic rnw,
   output logic miso,
   output logic swclk,
   inout  wire  swdio
);

   typedef enum logic [1:0] {
      ST_RELEASE = 2'd0,
      ST_DRIVE   = 2'd1,
      ST_SAMPLE  = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;
   logic   dout_q;
   logic   dout_d;
   logic   din_q;
   logic   din_d;
   logic   miso_q;
   logic   miso_d;
   logic   oe_q;
   logic   oe_d;

   // The target samples on rising swclk, i.e. halfway between our launch edges.
   assign swclk = ~sck;

   // Only the registered output enable lets the probe drive the wire.
   assign swdio = oe_q ? dout_q : 1'bz;

   assign miso = miso_q;

   // Next-state logic: one RELEASE cycle separates every direction change.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RELEASE: begin
            if (rnw) begin
               state_d = ST_SAMPLE;
            end else begin
               state_d = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (rnw) begin
               state_d = ST_RELEASE;
            end else begin
               state_d = ST_DRIVE;
            end
         end
         ST_SAMPLE: begin
            if (rnw) begin
               state_d = ST_SAMPLE;
            end else begin
               state_d = ST_RELEASE;
            end
         end
         default: begin
            state_d = ST_RELEASE;
         end
      endcase
   end

   // Datapath: write bit captured every edge, read bit captured only while sampling.
   always_comb begin
      dout_d = mosi;
      din_d  = din_q;
      if (state_q == ST_SAMPLE) begin
         din_d = swdio;
      end else begin
         din_d = din_q;
      end
   end

   // Output enable and miso are computed from next-state values so both are true flops.
   always_comb begin
      oe_d   = 1'b0;
      miso_d = 1'b0;
      case (state_d)
         ST_DRIVE: begin
            oe_d   = 1'b1;
            miso_d = dout_d;
         end
         ST_SAMPLE: begin
            oe_d   = 1'b0;
            miso_d = din_d;
         end
         ST_RELEASE: begin
            oe_d   = 1'b0;
            miso_d = 1'b0;
         end
         default: begin
            oe_d   = 1'b0;
            miso_d = 1'b0;
         end
      endcase
   end

   // State and data registers; reset overrides direction request and data.
   always_ff @(posedge sck) begin
      if (rst_n) begin
         state_q <= ST_RELEASE;
         dout_q  <= 1'b0;
         din_q   <= 1'b0;
         miso_q  <= 1'b0;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dout_q  <= dout_d;
         din_q   <= din_d;
         miso_q  <= miso_d;
         oe_q    <= oe_d;
      end
   end

endmodule

// File: tb/tb_swd_bridge_top.sv
// Testbench for swd_bridge_top: directed reset / write / read / turnaround
// sequences followed by random traffic, all checked against a bit-level
// behavioural model of the bridge. An external "target" driver plus a pull-up
// model the SWD connector; the driver only launches on falling sck (rising
// swclk) and only while the bridge has released the line.

module tb_swd_bridge_top;

   logic sck = 1'b0;
   logic rst_n;
   logic mosi;
   logic rnw;
   logic miso;
   logic swclk;
   logic ext_en;
   logic ext_val;
   wire  swdio_w;

   int n_asserts = 0;
   int n_fail    = 0;

   // Behavioural model: 0 = released, 1 = probe drives, 2 = target drives
   int m_mode = 0;
   logic m_dout = 1'b0;
   logic m_din  = 1'b0;

   assign swdio_w = ext_en ? ext_val : 1'bz;
   pullup (swdio_w);

   swd_bridge_top dut (
      .sck   (sck),
      .rst_n (rst_n),
      .mosi  (mosi),
      .rnw   (rnw),
      .miso  (miso),
      .swclk (swclk),
      .swdio (swdio_w)
   );

   always #5 sck = ~sck;

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // One host bit period: apply inputs on falling sck, model the rising edge, check after it.
   task automatic cycle(input logic r, input logic w_rnw, input logic b,
                        input logic e_en, input logic e_val, input string tag);
      logic line_v;
      int   want;
      logic exp_line;
      logic exp_miso;
      @(negedge sck);
      rst_n   = r;
      rnw     = w_rnw;
      mosi    = b;
      // target may drive only while the probe is sampling, or while reset holds the line free
      ext_en  = e_en && ((m_mode == 2) || ((m_mode == 0) && r));
      ext_val = e_val;
      #1;
      chk({tag, "_swclk_hi"}, swclk, ~sck);
      line_v = (m_mode == 1) ? m_dout : (ext_en ? ext_val : 1'b1);
      @(posedge sck);
      if (r) begin
         m_mode = 0;
         m_dout = 1'b0;
         m_din  = 1'b0;
      end else begin
         want = w_rnw ? 2 : 1;
         if (m_mode == 2) m_din = line_v;
         m_dout = b;
         if (m_mode == 0) m_mode = want;
         else if (m_mode != want) m_mode = 0;
      end
      #1;
      exp_miso = (m_mode == 1) ? m_dout : ((m_mode == 2) ? m_din : 1'b0);
      exp_line = (m_mode == 1) ? m_dout : (ext_en ? ext_val : 1'b1);
      chk({tag, "_swclk_lo"}, swclk, ~sck);
      chk({tag, "_miso"}, miso, exp_miso);
      chk({tag, "_swdio"}, swdio_w, exp_line);
   endtask

   initial begin
      logic [7:0] wbyte;
      logic [7:0] rbyte;
      logic       cur_rnw;
      logic       r;
      rst_n   = 1'b1;
      rnw     = 1'b0;
      mosi    = 1'b0;
      ext_en  = 1'b0;
      ext_val = 1'b0;

      // reset with nobody on the line: pull-up must win, miso low
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rst_free");
      // external line reset: 64 ones then 50 zeros while bridge is in reset
      for (int i = 0; i < 64; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b1, "rst_hold1");
      for (int i = 0; i < 50; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, "rst_hold0");
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rst_last");

      // write stream 0xA5, MSB first
      wbyte = 8'hA5;
      for (int i = 7; i >= 0; i--) cycle(1'b0, 1'b0, wbyte[i], 1'b0, 1'b0, "wr_a5");

      // turnaround write->read: one released cycle, target held off
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "ta_w2r");
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "rd_first");
      // read stream 0x3C launched by the target on rising swclk
      rbyte = 8'h3C;
      for (int i = 7; i >= 0; i--) cycle(1'b0, 1'b1, 1'b0, 1'b1, rbyte[i], "rd_3c");

      // turnaround read->write: target releases, one Z cycle, then drive
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "ta_r2w");
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "wr_after_ta");
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "wr_after_ta2");

      // rnw toggling every cycle
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'(i % 2), 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), "toggle");

      // reset mid-write, with mosi = 0 and mosi = 1
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "pre_rst0");
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "pre_rst0b");
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rst_mid0");
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "post_rst0");
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "pre_rst1");
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "rst_mid1");
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst1");

      // random traffic with persistent direction and occasional reset
      cur_rnw = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) cur_rnw = ~cur_rnw;
         r = ($urandom_range(0, 31) == 0);
         cycle(r, cur_rnw, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
               1'($urandom_range(0, 1)), "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
